// File: rtl/line_reader.sv
// line_reader: fetches sequential cache lines from the memory block, one request
// outstanding at a time, and serialises each line as a valid/ready word stream.
module line_reader #(
  parameter int unsigned LINE_W = 512,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADDR_W = 42,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              buffer_addr_valid,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_lines,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_req_ready,
  input  logic              rd_resp_valid,
  input  logic [LINE_W-1:0] rd_resp_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              word_last,
  input  logic              word_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WORDS = LINE_W / WORD_W;
  localparam int unsigned IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                done_d;
  logic                req_valid_d;
  logic                word_valid_d;
  logic                word_last_d;
  logic                busy_d;
  logic                last_idx;

  assign last_idx = (idx_q == IDX_W'(WORDS - 1));

  // Next-state and datapath; outputs are derived from the next state so they can be registered
  always_comb begin
    state_d = state_q;
    addr_d  = rd_req_addr;
    rem_d   = rem_q;
    idx_d   = idx_q;
    line_d  = line_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && buffer_addr_valid) begin
          if (num_lines != '0) begin
            state_d = REQ;
            addr_d  = base_addr;
            rem_d   = num_lines;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (rd_req_ready) begin
          state_d = WAIT;
          addr_d  = rd_req_addr + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
        end
      end
      WAIT: begin
        if (rd_resp_valid) begin
          state_d = DRAIN;
          line_d  = rd_resp_data;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        // The buffer shifts down so the current word always sits in the low bits
        if (word_ready) begin
          line_d = line_q >> WORD_W;
          idx_d  = idx_q + IDX_W'(1);
          if (last_idx) begin
            if (rem_q != '0) begin
              state_d = REQ;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    req_valid_d  = (state_d == REQ);
    word_valid_d = (state_d == DRAIN);
    busy_d       = (state_d != IDLE);
    word_last_d  = (state_d == DRAIN) && (idx_d == IDX_W'(WORDS - 1)) && (rem_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_req_addr  <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      line_q       <= '0;
      rd_req_valid <= 1'b0;
      word_valid   <= 1'b0;
      word_last    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_req_addr  <= addr_d;
      rem_q        <= rem_d;
      idx_q        <= idx_d;
      line_q       <= line_d;
      rd_req_valid <= req_valid_d;
      word_valid   <= word_valid_d;
      word_last    <= word_last_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  assign word_data = line_q[WORD_W-1:0];

endmodule

// File: tb/tb_line_reader.sv
// Directed bench for line_reader: a table of read commands replayed against a
// small memory responder, plus hand-written edge-command and reset sequences.
module tb_line_reader;

  logic         clk;
  logic         rst_n;
  logic         buffer_addr_valid;
  logic         start;
  logic [41:0]  base_addr;
  logic [15:0]  num_lines;
  logic         rd_req_valid;
  logic [41:0]  rd_req_addr;
  logic         rd_req_ready;
  logic         rd_resp_valid;
  logic [511:0] rd_resp_data;
  logic         word_valid;
  logic [31:0]  word_data;
  logic         word_last;
  logic         word_ready;
  logic         busy;
  logic         done;

  int passed = 0;
  int total  = 0;

  line_reader dut (
    .clk(clk), .rst_n(rst_n), .buffer_addr_valid(buffer_addr_valid),
    .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
    .word_ready(word_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [41:0] base;
    logic [15:0] n;
    int          stall;
    bit          toggle;
    int          stray_at;
    logic [41:0] exp_first;
    logic [41:0] exp_last;
    int          exp_words;
    int          exp_reqs;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pat(input int l, input int k);
    return 32'((l << 16) | k);
  endfunction

  function automatic logic [511:0] make_line(input int l);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = pat(l, k);
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, rd_req_valid, 0);
    chk({tag, "_req_addr"}, rd_req_addr, 0);
    chk({tag, "_word_valid"}, word_valid, 0);
    chk({tag, "_word_data"}, word_data, 0);
    chk({tag, "_word_last"}, word_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Issue one command and act as memory and consumer until done
  task automatic run_cmd(input vec_t v);
    int words = 0, lasts = 0, reqs = 0, stall_cnt = 0, resp_wait = 0, lines_resp = 0;
    int resp_cyc = 0, final_cyc = -1;
    bit got_done = 0, accepted_prev = 0, stalled_prev = 0;
    logic [41:0] first_addr = '0, last_addr = '0, held_addr = '0;
    logic [31:0] prev_data = '0;
    int total_w;
    total_w = 16 * int'(v.n);
    @(negedge clk);
    base_addr = v.base; num_lines = v.n; start = 1'b1; buffer_addr_valid = 1'b1;
    word_ready = 1'b1; rd_req_ready = 1'b0;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      start = 1'b0;
      if (it == v.stray_at) begin
        start = 1'b1; base_addr = 42'h777; num_lines = 16'd9;
      end
      if (it == 0) begin
        chk("start_req_valid", rd_req_valid, 1);
        chk("start_busy", busy, 1);
      end
      if (accepted_prev) chk("req_drop", rd_req_valid, 0);
      accepted_prev = 0;
      if (done) begin
        got_done = 1;
        chk("done_time", it, final_cyc + 1);
        chk("done_busy", busy, 0);
        if (!v.toggle) chk("done_latency", it - resp_cyc, 17);
        break;
      end
      rd_resp_valid = 1'b0;
      if (resp_wait > 0) begin
        resp_wait--;
        if (resp_wait == 0) begin
          rd_resp_valid = 1'b1;
          rd_resp_data  = make_line(lines_resp);
          lines_resp++;
          resp_cyc = it;
        end
      end
      rd_req_ready = 1'b0;
      if (rd_req_valid) begin
        if (stall_cnt == 0) begin
          held_addr = rd_req_addr;
          if (reqs == 0) first_addr = rd_req_addr;
          chk("req_addr", rd_req_addr, 42'(v.base + 42'(reqs)));
        end else begin
          chk("req_hold", rd_req_addr, held_addr);
        end
        if (stall_cnt == v.stall) begin
          rd_req_ready = 1'b1; reqs++; last_addr = held_addr;
          stall_cnt = 0; resp_wait = 2; accepted_prev = 1;
        end else begin
          stall_cnt++;
        end
      end
      if (word_valid) begin
        if (stalled_prev) chk("word_hold", word_data, prev_data);
        chk("word_data", word_data, pat(words / 16, words % 16));
        chk("word_last", word_last, (words == total_w - 1) ? 1 : 0);
        prev_data = word_data;
      end
      word_ready = v.toggle ? ((it % 2) == 1) : 1'b1;
      stalled_prev = word_valid && !word_ready;
      if (word_valid && word_ready) begin
        words++;
        if (word_last) lasts++;
        if (words == total_w) final_cyc = it;
      end
    end
    chk("done_seen", got_done, 1);
    chk("first_addr", first_addr, v.exp_first);
    chk("last_addr", last_addr, v.exp_last);
    chk("word_count", words, v.exp_words);
    chk("req_count", reqs, v.exp_reqs);
    chk("last_count", lasts, 1);
    start = 1'b0; rd_req_ready = 1'b0; rd_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{42'h100, 16'd1, 0, 1'b0, -1, 42'h100, 42'h100, 16, 1};
    vecs[1] = '{42'h100, 16'd3, 4, 1'b0, -1, 42'h100, 42'h102, 48, 3};
    vecs[2] = '{42'h200, 16'd2, 0, 1'b1, 6, 42'h200, 42'h201, 32, 2};
    vecs[3] = '{42'h3FF_FFFF_FFFF, 16'd2, 0, 1'b0, -1, 42'h3FF_FFFF_FFFF, 42'h0, 32, 2};

    rst_n = 1'b0; start = 1'b0; buffer_addr_valid = 1'b1; base_addr = '0; num_lines = '0;
    rd_req_ready = 1'b0; rd_resp_valid = 1'b0; rd_resp_data = '0; word_ready = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_cmd(vecs[i]);

    // Zero-length command: done next cycle, nothing requested
    @(negedge clk);
    base_addr = 42'h55; num_lines = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_req", rd_req_valid, 0);
    @(negedge clk);
    chk("zero_done_once", done, 0);
    chk("zero_req_after", rd_req_valid, 0);

    // Start without a host buffer is ignored
    buffer_addr_valid = 1'b0; base_addr = 42'h9; num_lines = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("nobuf_busy", busy, 0);
    chk("nobuf_req", rd_req_valid, 0);
    @(negedge clk);
    chk("nobuf_done", done, 0);
    buffer_addr_valid = 1'b1;

    // Stray response in IDLE is ignored
    rd_resp_valid = 1'b1; rd_resp_data = make_line(5);
    @(negedge clk);
    rd_resp_valid = 1'b0;
    chk("stray_word_valid", word_valid, 0);
    chk("stray_busy", busy, 0);

    // Reset asserted while word 7 is on the output
    word_ready = 1'b1;
    base_addr = 42'h40; num_lines = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_seq_req", rd_req_valid, 1);
    rd_req_ready = 1'b1;
    @(negedge clk);
    rd_req_ready = 1'b0;
    rd_resp_valid = 1'b1; rd_resp_data = make_line(0);
    @(negedge clk);
    rd_resp_valid = 1'b0;
    chk("rst_seq_word0", word_data, 32'h0);
    repeat (7) @(negedge clk);
    chk("rst_seq_word7", word_data, 32'h7);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rd_resp_valid = 1'b1; rd_resp_data = make_line(3);
    rst_n = 1'b1;
    @(negedge clk);
    rd_resp_valid = 1'b0;
    chk("late_resp_word_valid", word_valid, 0);
    chk("late_resp_done", done, 0);
    chk("late_resp_busy", busy, 0);

    run_cmd(vecs[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
